lfsr_fib_param: RTL

LFSR_FIB_PARAM -- requirements
Module: lfsr_fib_param

---
 rtl/lfsr_fib_param.sv | 113 +++++++++++
 1 files changed

// File: rtl/lfsr_fib_param.sv
// Parameterised Fibonacci LFSR with XOR/XNOR feedback, seed loading and lock-up detection.
// It also measures the sequence period and raises a one-cycle wrap pulse when the start state recurs.
module lfsr_fib_param #(
  parameter int               WIDTH        = 11,
  parameter logic [WIDTH-1:0] TAPS         = 11'h500,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             xnor_mode,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] step_cnt,
  output logic [WIDTH-1:0] period_len,
  output logic             wrap,
  output logic             busy,
  output logic             lock_err
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_fib_param: WIDTH must be within 3..32");
  end
  if (!TAPS[WIDTH-1]) begin : g_bad_taps
    $error("lfsr_fib_param: TAPS[WIDTH-1] must be set");
  end
  if (DEFAULT_SEED == '0) begin : g_bad_seed
    $error("lfsr_fib_param: DEFAULT_SEED must not be the XOR lock-up value");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e           r_fsm;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_step_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_mode;
  logic             r_wrap;

  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic             w_hit;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_seed_is_lock;

  assign w_fb           = (^(r_state & TAPS)) ^ r_mode;
  assign w_next         = {r_state[WIDTH-2:0], w_fb};
  assign w_hit          = (w_next == r_start);
  assign w_cnt_inc      = (&r_step_cnt) ? r_step_cnt : r_step_cnt + WIDTH'(1);
  // The lock value depends on the mode being loaded, not the mode currently held.
  assign w_seed_is_lock = xnor_mode ? (&seed) : ~(|seed);

  // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm      <= ST_IDLE;
      r_state    <= DEFAULT_SEED;
      r_start    <= DEFAULT_SEED;
      r_mode     <= 1'b0;
      r_step_cnt <= '0;
      r_period   <= '0;
      r_wrap     <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (load) begin
        r_state    <= seed;
        r_start    <= seed;
        r_mode     <= xnor_mode;
        r_step_cnt <= '0;
        r_period   <= '0;
        r_fsm      <= w_seed_is_lock ? ST_LOCKED : ST_IDLE;
      end else begin
        case (r_fsm)
          // Leaving IDLE performs the first shift on the same edge, so stepping starts
          // on the cycle after en is seen rather than one cycle later.
          ST_IDLE, ST_RUN: begin
            if (en) begin
              r_fsm   <= ST_RUN;
              r_state <= w_next;
              if (w_hit) begin
                r_wrap     <= 1'b1;
                r_period   <= w_cnt_inc;
                r_step_cnt <= '0;
              end else begin
                r_step_cnt <= w_cnt_inc;
              end
            end else begin
              r_fsm <= ST_IDLE;
            end
          end
          ST_LOCKED: begin
            r_fsm <= ST_LOCKED;
          end
          default: r_fsm <= ST_IDLE;
        endcase
      end
    end
  end

  assign out        = r_state;
  assign step_cnt   = r_step_cnt;
  assign period_len = r_period;
  assign wrap       = r_wrap;
  assign busy       = (r_fsm == ST_RUN);
  assign lock_err   = (r_fsm == ST_LOCKED);

endmodule
